sw_debouncer: RTL and testbench
===============================

SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a level change.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000: cycles in the pressed state before a long-press pulse.
REQ-003 SHALL have parameter PUSH_ACTIVE_LOW, default 1: push pins read 0 when pressed.
REQ-004 iSysClk  input  1  system clock; the only clock.
REQ-005 iSysRst  input  1  reset; asynchronous, active-low.
REQ-006 iUserDipSw  input  4  raw asynchronous DIP pins; active-high.
REQ-007 iUserPushSw  input  4  raw asynchronous push pins; polarity per PUSH_ACTIVE_LOW.
REQ-008 oUserDipSw  output  4  debounced DIP level.
REQ-009 oUserPushSw  output  4  debounced push level; 1 = pressed.
REQ-010 oPushRise  output  4  one-cycle pulse on accepted press.
REQ-011 oPushFall  output  4  one-cycle pulse on accepted release.
REQ-012 oPushLong  output  4  one-cycle pulse after LONG_CYCLES held.

Function
REQ-013 Each of the 8 inputs SHALL pass a 2-flop synchronizer; push bits are inverted after synchronization when PUSH_ACTIVE_LOW=1.
REQ-014 Each channel SHALL run an independent FSM: RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-015 RELEASED -> DEB_PRESS when the synchronized sample is 1; counter loads 1.
REQ-016 In DEB_PRESS: sample 1 increments the counter; sample 0 returns to RELEASED and clears the counter.
REQ-017 DEB_PRESS -> PRESSED on the edge where the counter would reach DEBOUNCE_CYCLES; the level goes 1 on that edge.
REQ-018 PRESSED/DEB_RELEASE SHALL mirror REQ-015..017 with polarity reversed; the level goes 0 on entry to RELEASED.
REQ-019 Total latency SHALL be 2 + DEBOUNCE_CYCLES edges from a pin change to the level output change.
REQ-020 oPushRise/oPushFall SHALL assert in the same cycle the level changes, for exactly one cycle.
REQ-021 The long-press counter SHALL clear on entry to PRESSED and count while in PRESSED or DEB_RELEASE.
REQ-022 oPushLong SHALL pulse once when the long counter reaches LONG_CYCLES, then saturate; there is no repeat within the same press.
REQ-023 A bounce during DEB_RELEASE SHALL NOT reset the long counter.
REQ-024 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1); counters SHALL never wrap.
REQ-025 DIP channels SHALL use the same FSM; their pulse and long logic SHALL be unused and optimised away.
REQ-026 Simultaneous changes on several channels SHALL be handled independently, with no arbitration.

Reset
REQ-027 While iSysRst=0, all FSMs SHALL be RELEASED, all counters 0, and all outputs 0.
REQ-028 Synchronizer flops SHALL reset to the inactive pin level: 1 for push when PUSH_ACTIVE_LOW, else 0.
REQ-029 Reset mid-debounce or mid-press SHALL abort without emitting any pulse.
REQ-030 A switch held through reset release SHALL be detected as a fresh press after 2 + DEBOUNCE_CYCLES edges.

Structure
REQ-031 Package sw_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES/LONG_CYCLES constants.
REQ-032 The per-channel synchronizer, FSM and counters SHALL be sub-module sw_debounce_ch, instantiated 8 times with a parameter enabling the long-press logic.
REQ-033 The block SHALL sit between the pins and the system processor, replacing the direct pin-to-logic path.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, PUSH_ACTIVE_LOW=1)
REQ-034 Push[0] driven 0 before edge 0 and held -> oUserPushSw[0]=1 and a one-cycle oPushRise[0] after edge 10; other bits stay 0.
REQ-035 Push[1] driven 0 for 5 cycles, then 1 -> no change on any output.
REQ-036 Push[2] held 60 cycles -> oPushLong[2] single pulse 32 edges after the rise; on release, oPushFall[2] after 10 edges, with no second long pulse.
REQ-037 Push[3] pressed, reset asserted at debounce count 4 -> all outputs 0 immediately; after reset release with the switch still held -> rise after 10 edges.
REQ-038 All push and DIP pins change in the same cycle -> all 8 levels update on the same edge (edge 10) and four rise pulses coincide.
REQ-039 Dip[2] set to 1 -> oUserDipSw[2]=1 after edge 10; oPushRise/Fall/Long stay 0.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and defaults for the switch debouncer
package sw_pkg;

    localparam int unsigned NUM_SW              = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } sw_state_e;

    // One width serves both counters so neither can ever wrap.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sw_debouncer_if.sv
// rtl/sw_debouncer_if.sv - raw switch pins in, debounced levels and events out
interface sw_debouncer_if;
    import sw_pkg::*;

    logic [NUM_SW-1:0] iUserDipSw;
    logic [NUM_SW-1:0] iUserPushSw;
    logic [NUM_SW-1:0] oUserDipSw;
    logic [NUM_SW-1:0] oUserPushSw;
    logic [NUM_SW-1:0] oPushRise;
    logic [NUM_SW-1:0] oPushFall;
    logic [NUM_SW-1:0] oPushLong;

    modport master (
        output iUserDipSw, iUserPushSw,
        input  oUserDipSw, oUserPushSw, oPushRise, oPushFall, oPushLong
    );

    modport slave (
        input  iUserDipSw, iUserPushSw,
        output oUserDipSw, oUserPushSw, oPushRise, oPushFall, oPushLong
    );

endinterface

// File: rtl/sw_debounce_ch.sv
// rtl/sw_debounce_ch.sv - one switch channel: synchronizer, debounce FSM, press events
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          INVERT          = 1'b0,
    parameter bit          EN_EVENTS       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_pulse
);
    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          sample;
    sw_state_e     state;
    logic [CW-1:0] deb_cnt;
    logic          deb_done;
    logic          press_evt;
    logic          release_evt;

    // Flops come out of reset at the idle pin level so reset never fakes a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{INVERT}};
        else        sync_q <= {sync_q[0], pin};
    end

    assign sample      = sync_q[1] ^ INVERT;
    assign deb_done    = (deb_cnt + CW'(1)) == DEB_MAX;
    assign press_evt   = sample && deb_done && (state == ST_RELEASED || state == ST_DEB_PRESS);
    assign release_evt = !sample && deb_done && (state == ST_PRESSED || state == ST_DEB_RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RELEASED;
            deb_cnt <= '0;
            level   <= 1'b0;
        end else begin
            unique case (state)
                ST_RELEASED, ST_DEB_PRESS: begin
                    if (press_evt) begin
                        state   <= ST_PRESSED;
                        deb_cnt <= '0;
                        level   <= 1'b1;
                    end else if (sample) begin
                        state   <= ST_DEB_PRESS;
                        deb_cnt <= deb_cnt + CW'(1);
                    end else begin
                        state   <= ST_RELEASED;
                        deb_cnt <= '0;
                    end
                end
                ST_PRESSED, ST_DEB_RELEASE: begin
                    if (release_evt) begin
                        state   <= ST_RELEASED;
                        deb_cnt <= '0;
                        level   <= 1'b0;
                    end else if (!sample) begin
                        state   <= ST_DEB_RELEASE;
                        deb_cnt <= deb_cnt + CW'(1);
                    end else begin
                        state   <= ST_PRESSED;
                        deb_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_RELEASED;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    if (EN_EVENTS) begin : g_events
        localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
        logic [CW-1:0] long_cnt;
        logic          long_active;

        // Keeps counting through release bounces; saturates so the pulse fires once per press.
        assign long_active = (state == ST_PRESSED) || (state == ST_DEB_RELEASE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rise       <= 1'b0;
                fall       <= 1'b0;
                long_pulse <= 1'b0;
                long_cnt   <= '0;
            end else begin
                rise       <= press_evt;
                fall       <= release_evt;
                long_pulse <= 1'b0;
                if (press_evt) begin
                    long_cnt <= '0;
                end else if (long_active && long_cnt < LONG_MAX) begin
                    long_cnt   <= long_cnt + CW'(1);
                    long_pulse <= (long_cnt + CW'(1)) == LONG_MAX;
                end
            end
        end
    end else begin : g_no_events
        assign rise       = 1'b0;
        assign fall       = 1'b0;
        assign long_pulse = 1'b0;
    end

endmodule

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - debounces four DIP and four push switches between pins and processor
module sw_debouncer
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned PUSH_ACTIVE_LOW = 1
) (
    input  logic          iSysClk,
    input  logic          iSysRst,
    sw_debouncer_if.slave pins
);
    logic [NUM_SW-1:0] push_level, push_rise, push_fall, push_long;
    logic [NUM_SW-1:0] dip_level;
    logic [NUM_SW-1:0] dip_rise_unused, dip_fall_unused, dip_long_unused;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .INVERT          (PUSH_ACTIVE_LOW != 0),
            .EN_EVENTS       (1'b1)
        ) u_push (
            .clk        (iSysClk),
            .rst_n      (iSysRst),
            .pin        (pins.iUserPushSw[i]),
            .level      (push_level[i]),
            .rise       (push_rise[i]),
            .fall       (push_fall[i]),
            .long_pulse (push_long[i])
        );

        sw_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .INVERT          (1'b0),
            .EN_EVENTS       (1'b0)
        ) u_dip (
            .clk        (iSysClk),
            .rst_n      (iSysRst),
            .pin        (pins.iUserDipSw[i]),
            .level      (dip_level[i]),
            .rise       (dip_rise_unused[i]),
            .fall       (dip_fall_unused[i]),
            .long_pulse (dip_long_unused[i])
        );
    end

    assign pins.oUserDipSw  = dip_level;
    assign pins.oUserPushSw = push_level;
    assign pins.oPushRise   = push_rise;
    assign pins.oPushFall   = push_fall;
    assign pins.oPushLong   = push_long;

endmodule

// File: tb/tb_sw_debouncer.sv
// tb/tb_sw_debouncer.sv - scoreboard bench for sw_debouncer against a sample-window model
module tb_sw_debouncer;

    localparam int DEB = 8;
    localparam int LNG = 32;

    typedef struct {
        int         cyc;
        logic [19:0] vec;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    sw_debouncer_if pif();

    sw_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .PUSH_ACTIVE_LOW (1)
    ) dut (
        .iSysClk (clk),
        .iSysRst (rst_n),
        .pins    (pif)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] dut_vec();
        return {pif.oUserDipSw, pif.oUserPushSw, pif.oPushRise, pif.oPushFall, pif.oPushLong};
    endfunction

    task automatic check_vec(input string name, input logic [19:0] req);
        checks++;
        if (dut_vec() !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, dut_vec(), req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level flips once the last DEB samples (pins seen two edges late)
    // all disagree with it; a long pulse comes LNG edges after a rise while still held.
    bit          hist_q[8][$];
    bit          samp_q[8][$];
    bit          lvl[8];
    int          rise_e[8];
    logic [19:0] exp_prev = '0;

    initial begin
        forever begin
            logic [3:0] nrise, nfall, nlong, plvl, dlvl;
            logic [19:0] nv;
            @(posedge clk);
            cyc++;
            nrise = '0; nfall = '0; nlong = '0;
            if (!rst_n) begin
                for (int ch = 0; ch < 8; ch++) begin
                    hist_q[ch].delete();
                    samp_q[ch].delete();
                    lvl[ch]    = 1'b0;
                    rise_e[ch] = 0;
                end
            end else begin
                for (int ch = 0; ch < 8; ch++) begin
                    bit p, s, all_diff;
                    p = (ch < 4) ? ~pif.iUserPushSw[ch] : pif.iUserDipSw[ch-4];
                    hist_q[ch].push_back(p);
                    if (hist_q[ch].size() > 4) void'(hist_q[ch].pop_front());
                    s = (hist_q[ch].size() >= 3) ? hist_q[ch][hist_q[ch].size()-3] : 1'b0;
                    samp_q[ch].push_back(s);
                    if (samp_q[ch].size() > DEB) void'(samp_q[ch].pop_front());
                    if (ch < 4 && lvl[ch] && (cyc - rise_e[ch] == LNG)) nlong[ch[1:0]] = 1'b1;
                    if (samp_q[ch].size() == DEB) begin
                        all_diff = 1'b1;
                        foreach (samp_q[ch][k]) if (samp_q[ch][k] == lvl[ch]) all_diff = 1'b0;
                        if (all_diff) begin
                            lvl[ch] = ~lvl[ch];
                            if (ch < 4) begin
                                if (lvl[ch]) begin
                                    nrise[ch[1:0]] = 1'b1;
                                    rise_e[ch]     = cyc;
                                end else begin
                                    nfall[ch[1:0]] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                plvl[i] = lvl[i];
                dlvl[i] = lvl[i+4];
            end
            nv = {dlvl, plvl, nrise, nfall, nlong};
            if (nv != exp_prev) begin
                exp_q.push_back('{cyc, nv});
                exp_prev = nv;
            end
        end
    end

    initial begin
        logic [19:0] last;
        logic [19:0] cur;
        exp_t        e;
        last = '0;
        forever begin
            @(negedge clk);
            cur = dut_vec();
            if (cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.vec !== cur || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL output_event got cyc=%0d vec=%h required cyc=%0d vec=%h",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
                last = cur;
            end
        end
    end

    initial begin
        pif.iUserPushSw = 4'hF;
        pif.iUserDipSw  = 4'h0;
        rst_n = 1'b0;
        wait_cyc(3);
        check_vec("reset_state", 20'h0);
        #1 rst_n = 1'b1;
        wait_cyc(2);

        // single press and release
        pif.iUserPushSw = 4'b1110; wait_cyc(20);
        pif.iUserPushSw = 4'hF;    wait_cyc(20);

        // short glitch must be filtered
        pif.iUserPushSw = 4'b1101; wait_cyc(5);
        pif.iUserPushSw = 4'hF;    wait_cyc(20);

        // long press, then long pulse landing inside a bouncy release
        pif.iUserPushSw = 4'b1011; wait_cyc(60);
        pif.iUserPushSw = 4'hF;    wait_cyc(20);
        pif.iUserPushSw = 4'b1011; wait_cyc(30);
        pif.iUserPushSw = 4'hF;    wait_cyc(4);
        pif.iUserPushSw = 4'b1011; wait_cyc(3);
        pif.iUserPushSw = 4'hF;    wait_cyc(25);

        // reset while push0 pressed and push3 mid-debounce, both held through release
        pif.iUserPushSw = 4'b1110; wait_cyc(15);
        pif.iUserPushSw = 4'b0110; wait_cyc(6);
        #1 rst_n = 1'b0;
        #1 check_vec("reset_abort", 20'h0);
        wait_cyc(3);
        #1 rst_n = 1'b1;
        wait_cyc(15);
        pif.iUserPushSw = 4'hF;    wait_cyc(20);

        // every pin at once
        pif.iUserPushSw = 4'h0; pif.iUserDipSw = 4'hF; wait_cyc(20);
        pif.iUserPushSw = 4'hF; pif.iUserDipSw = 4'h0; wait_cyc(20);

        // single DIP
        pif.iUserDipSw = 4'b0100; wait_cyc(20);
        pif.iUserDipSw = 4'b0000; wait_cyc(20);

        // random patterns with holds from bounce-short to long-press length
        for (int it = 0; it < 40; it++) begin
            pif.iUserPushSw = 4'($urandom);
            pif.iUserDipSw  = 4'($urandom);
            wait_cyc(int'($urandom_range(1, 50)));
            if (it == 20) begin
                #1 rst_n = 1'b0;
                wait_cyc(2);
                #1 rst_n = 1'b1;
            end
        end
        pif.iUserPushSw = 4'hF;
        pif.iUserDipSw  = 4'h0;
        wait_cyc(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
